// File: rtl/pc_redirect_ctrl.sv
// ----------------------------------------------------------------------------
// pc_redirect_ctrl
//
// Turns the execute-stage branch result (PcSel / BrPC) of the 5-stage RV32
// core into a one-cycle PC load plus IF/ID, ID/EX and EX/MEM flushes. A taken
// branch seen while the pipeline is stalled is parked in PEND until the stall
// clears. The block also keeps saturating branch/taken statistics counters
// and a sticky misaligned-target flag.
//
// Ports:
//   clk, reset       core clock (rising edge), synchronous active-high reset
//   ex_valid         EX holds a real (non-bubble) instruction
//   ex_branch        EX instruction is a branch/jal/jalr
//   ex_pcsel         branch unit reports taken
//   ex_brpc          branch unit target address (32 bits)
//   stall_in         pipeline frozen this cycle
//   pc_load          PC register loads pc_target this cycle
//   pc_target        word-aligned redirect target, PC_W bits
//   flush_ifid/idex/exmem  clear the pipeline registers at the next edge
//   redirect_busy    FSM is not IDLE
//   misalign_err     sticky: some captured target had ex_brpc[1:0] != 0
//   br_count         accepted branch instructions (saturating)
//   taken_count      accepted taken redirects (saturating)
//
// Every output comes straight from a flop; there is no input-to-output path.
// ----------------------------------------------------------------------------
module pc_redirect_ctrl #(
    parameter int PC_W  = 9,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_valid,
    input  logic             ex_branch,
    input  logic             ex_pcsel,
    input  logic [31:0]      ex_brpc,
    input  logic             stall_in,
    output logic             pc_load,
    output logic [PC_W-1:0]  pc_target,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             flush_exmem,
    output logic             redirect_busy,
    output logic             misalign_err,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] taken_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t            state_q,       state_d;
    logic [PC_W-1:0]   pend_tgt_q,    pend_tgt_d;
    logic [PC_W-1:0]   pc_target_q,   pc_target_d;
    logic              redirect_q,    redirect_d;
    logic              busy_q,        busy_d;
    logic              misalign_q,    misalign_d;
    logic [CNT_W-1:0]  br_count_q,    br_count_d;
    logic [CNT_W-1:0]  taken_count_q, taken_count_d;

    logic              accept;
    logic [PC_W-1:0]   aligned_tgt;

    // Address bits above the PC width are dropped by design.
    logic unused_brpc_hi;
    assign unused_brpc_hi = ^ex_brpc[31:PC_W];

    // EX inputs only matter in IDLE; in PEND/FLUSH the EX slot is either the
    // branch already captured or a wrong-path instruction.
    assign accept      = (state_q == IDLE) && ex_valid;
    assign aligned_tgt = {ex_brpc[PC_W-1:2], 2'b00};

    always_comb begin
        // NOTE: every variable gets a default before the case statement so no
        // path leaves one unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        pend_tgt_d    = pend_tgt_q;
        misalign_d    = misalign_q;
        br_count_d    = br_count_q;
        taken_count_d = taken_count_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (ex_branch && (br_count_q != CNT_MAX))
                        br_count_d = br_count_q + CNT_ONE;
                    if (ex_pcsel && (taken_count_q != CNT_MAX))
                        taken_count_d = taken_count_q + CNT_ONE;
                    if (ex_pcsel) begin
                        pend_tgt_d = aligned_tgt;
                        if (ex_brpc[1:0] != 2'b00)
                            misalign_d = 1'b1;
                        state_d = stall_in ? PEND : FLUSH;
                    end
                end
            end
            PEND: begin
                if (!stall_in)
                    state_d = FLUSH;
            end
            FLUSH: begin
                // Load/flush override the stall on the PC and pipeline
                // registers, so this state never waits.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from next-state so they line up with the
        // cycle in which the FSM sits in the corresponding state.
        redirect_d  = (state_d == FLUSH);
        busy_d      = (state_d != IDLE);
        // The visible target only moves when a load is issued; the pending
        // copy holds a parked target without disturbing pc_target.
        pc_target_d = redirect_d ? pend_tgt_d : pc_target_q;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops
        // sample their _d values from the same pre-edge snapshot.
        if (reset) begin
            state_q       <= IDLE;
            pend_tgt_q    <= '0;
            pc_target_q   <= '0;
            redirect_q    <= 1'b0;
            busy_q        <= 1'b0;
            misalign_q    <= 1'b0;
            br_count_q    <= '0;
            taken_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pend_tgt_q    <= pend_tgt_d;
            pc_target_q   <= pc_target_d;
            redirect_q    <= redirect_d;
            busy_q        <= busy_d;
            misalign_q    <= misalign_d;
            br_count_q    <= br_count_d;
            taken_count_q <= taken_count_d;
        end
    end

    assign pc_load       = redirect_q;
    assign flush_ifid    = redirect_q;
    assign flush_idex    = redirect_q;
    assign flush_exmem   = redirect_q;
    assign pc_target     = pc_target_q;
    assign redirect_busy = busy_q;
    assign misalign_err  = misalign_q;
    assign br_count      = br_count_q;
    assign taken_count   = taken_count_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pc_redirect_ctrl
//
// Directed vectors, each carrying the hand-computed outputs expected after the
// clock edge that samples it. The driver pushes those expectations into a
// queue; a separate monitor pops one entry per cycle and compares.
// A second instance with 3-bit counters shares the same stimulus so counter
// saturation is reached within a few dozen cycles.
// ----------------------------------------------------------------------------
module tb_pc_redirect_ctrl;

    localparam int PC_W  = 9;
    localparam int CNT_W = 16;
    localparam int SAT_W = 3;
    localparam int SAT_MAX = (1 << SAT_W) - 1;

    typedef struct packed {
        logic             load;
        logic [PC_W-1:0]  tgt;
        logic             busy;
        logic             mis;
        logic [CNT_W-1:0] brc;
        logic [CNT_W-1:0] tkc;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             ex_valid, ex_branch, ex_pcsel, stall_in;
    logic [31:0]      ex_brpc;

    logic             pc_load, flush_ifid, flush_idex, flush_exmem;
    logic [PC_W-1:0]  pc_target;
    logic             redirect_busy, misalign_err;
    logic [CNT_W-1:0] br_count, taken_count;

    logic             s_pc_load, s_flush_ifid, s_flush_idex, s_flush_exmem;
    logic [PC_W-1:0]  s_pc_target;
    logic             s_redirect_busy, s_misalign_err;
    logic [SAT_W-1:0] s_br_count, s_taken_count;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    always #5 clk = ~clk;

    pc_redirect_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_pcsel(ex_pcsel),
        .ex_brpc(ex_brpc), .stall_in(stall_in),
        .pc_load(pc_load), .pc_target(pc_target),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex), .flush_exmem(flush_exmem),
        .redirect_busy(redirect_busy), .misalign_err(misalign_err),
        .br_count(br_count), .taken_count(taken_count)
    );

    pc_redirect_ctrl #(.PC_W(PC_W), .CNT_W(SAT_W)) dut_sat (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_pcsel(ex_pcsel),
        .ex_brpc(ex_brpc), .stall_in(stall_in),
        .pc_load(s_pc_load), .pc_target(s_pc_target),
        .flush_ifid(s_flush_ifid), .flush_idex(s_flush_idex), .flush_exmem(s_flush_exmem),
        .redirect_busy(s_redirect_busy), .misalign_err(s_misalign_err),
        .br_count(s_br_count), .taken_count(s_taken_count)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    function automatic logic [31:0] sat(input logic [CNT_W-1:0] v);
        return (v > CNT_W'(SAT_MAX)) ? 32'(SAT_MAX) : 32'(v);
    endfunction

    // Drive one vector before the next rising edge and queue what must be
    // visible after that edge.
    task automatic vec(input string nm, input bit rst, input bit v, input bit b,
                       input bit s, input logic [31:0] brpc, input bit st,
                       input bit load, input logic [PC_W-1:0] tgt, input bit busy,
                       input bit mis, input int brc, input int tkc);
        exp_t e;
        @(negedge clk);
        reset     = rst;
        ex_valid  = v;
        ex_branch = b;
        ex_pcsel  = s;
        ex_brpc   = brpc;
        stall_in  = st;
        e.load = load;
        e.tgt  = tgt;
        e.busy = busy;
        e.mis  = mis;
        e.brc  = CNT_W'(brc);
        e.tkc  = CNT_W'(tkc);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: one expectation per cycle, sampled 1ns after the rising edge.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check({nm, ".pc_load"},       32'(pc_load),       32'(e.load));
                check({nm, ".flush_ifid"},    32'(flush_ifid),    32'(e.load));
                check({nm, ".flush_idex"},    32'(flush_idex),    32'(e.load));
                check({nm, ".flush_exmem"},   32'(flush_exmem),   32'(e.load));
                check({nm, ".pc_target"},     32'(pc_target),     32'(e.tgt));
                check({nm, ".redirect_busy"}, 32'(redirect_busy), 32'(e.busy));
                check({nm, ".misalign_err"},  32'(misalign_err),  32'(e.mis));
                check({nm, ".br_count"},      32'(br_count),      32'(e.brc));
                check({nm, ".taken_count"},   32'(taken_count),   32'(e.tkc));
                check({nm, ".sat_pc_load"},   32'(s_pc_load),     32'(e.load));
                check({nm, ".sat_br_count"},  32'(s_br_count),    sat(e.brc));
                check({nm, ".sat_taken_count"}, 32'(s_taken_count), sat(e.tkc));
            end
        end
    end

    initial begin
        reset = 1'b1; ex_valid = 1'b0; ex_branch = 1'b0; ex_pcsel = 1'b0;
        ex_brpc = 32'h0; stall_in = 1'b0;

        //   name          rst v b s brpc          st  load tgt      busy mis br tk
        vec("reset0",      1, 0,0,0, 32'h0,        0,  0, 9'h000,  0, 0, 0, 0);
        vec("reset1",      1, 0,0,0, 32'h0,        0,  0, 9'h000,  0, 0, 0, 0);
        vec("t1_idle3",    0, 0,0,0, 32'h0,        0,  0, 9'h000,  0, 0, 0, 0);
        vec("t1_idle4",    0, 0,0,0, 32'h0,        0,  0, 9'h000,  0, 0, 0, 0);
        // Taken, no stall: load/flush in the following cycle.
        vec("t1_taken",    0, 1,1,1, 32'h0000_0040,0,  1, 9'h040,  1, 0, 1, 1);
        vec("t1_after",    0, 0,0,0, 32'h0,        0,  0, 9'h040,  0, 0, 1, 1);
        // Not-taken branches: only br_count moves.
        vec("t2_reset",    1, 0,0,0, 32'h0,        0,  0, 9'h000,  0, 0, 0, 0);
        vec("t2_nt1",      0, 1,1,0, 32'h100,      0,  0, 9'h000,  0, 0, 1, 0);
        vec("t2_nt2",      0, 1,1,0, 32'h100,      0,  0, 9'h000,  0, 0, 2, 0);
        vec("t2_nt3",      0, 1,1,0, 32'h100,      0,  0, 9'h000,  0, 0, 3, 0);
        // Stalled redirect: parked in PEND, pc_target unchanged until load.
        vec("t3_accept",   0, 1,1,1, 32'h88,       1,  0, 9'h000,  1, 0, 4, 1);
        vec("t3_stall_a",  0, 1,1,0, 32'h200,      1,  0, 9'h000,  1, 0, 4, 1);
        vec("t3_stall_b",  0, 1,1,1, 32'h200,      1,  0, 9'h000,  1, 0, 4, 1);
        vec("t3_stall_c",  0, 1,1,0, 32'h200,      1,  0, 9'h000,  1, 0, 4, 1);
        vec("t3_release",  0, 0,0,0, 32'h0,        0,  1, 9'h088,  1, 0, 4, 1);
        vec("t3_after",    0, 0,0,0, 32'h0,        0,  0, 9'h088,  0, 0, 4, 1);
        // Wrong-path taken branch during FLUSH is ignored and uncounted.
        vec("t4_first",    0, 1,1,1, 32'h20,       0,  1, 9'h020,  1, 0, 5, 2);
        vec("t4_wrong",    0, 1,1,1, 32'h60,       0,  0, 9'h020,  0, 0, 5, 2);
        vec("t4_after",    0, 0,0,0, 32'h0,        0,  0, 9'h020,  0, 0, 5, 2);
        // PcSel without Branch still redirects and counts as taken only.
        vec("nobr_taken",  0, 1,0,1, 32'h30,       0,  1, 9'h030,  1, 0, 5, 3);
        vec("nobr_after",  0, 0,0,0, 32'h0,        0,  0, 9'h030,  0, 0, 5, 3);
        vec("invalid",     0, 0,1,1, 32'h70,       0,  0, 9'h030,  0, 0, 5, 3);
        // Misaligned, over-wide target: 0xF26 -> 9 bits 0x126 -> aligned 0x124.
        vec("t5_mis",      0, 1,1,1, 32'h0000_0F26,0,  1, 9'h124,  1, 1, 6, 4);
        vec("t5_sticky",   0, 0,0,0, 32'h0,        0,  0, 9'h124,  0, 1, 6, 4);
        vec("t5_pend",     0, 1,1,1, 32'h10,       1,  0, 9'h124,  1, 1, 7, 5);
        vec("t5_release",  0, 0,0,0, 32'h0,        0,  1, 9'h010,  1, 1, 7, 5);
        vec("t5_idle",     0, 0,0,0, 32'h0,        0,  0, 9'h010,  0, 1, 7, 5);
        // FLUSH leaves for IDLE even if the stall rises during it.
        vec("fl_taken",    0, 1,1,1, 32'h44,       0,  1, 9'h044,  1, 1, 8, 6);
        vec("fl_stall",    0, 0,0,0, 32'h0,        1,  0, 9'h044,  0, 1, 8, 6);
        vec("sat_taken",   0, 1,1,1, 32'h50,       0,  1, 9'h050,  1, 1, 9, 7);
        vec("sat_idle",    0, 0,0,0, 32'h0,        0,  0, 9'h050,  0, 1, 9, 7);
        // Reset in the PEND cycle discards the parked redirect.
        vec("t6_pend",     0, 1,1,1, 32'h48,       1,  0, 9'h050,  1, 1, 10, 8);
        vec("t6_reset",    1, 1,1,1, 32'h4C,       0,  0, 9'h000,  0, 0, 0, 0);
        vec("t6_idle1",    0, 0,0,0, 32'h0,        0,  0, 9'h000,  0, 0, 0, 0);
        vec("t6_idle2",    0, 0,0,0, 32'h0,        0,  0, 9'h000,  0, 0, 0, 0);

        // Let the monitor drain, with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
